// File: rtl/ir_nec_pkg.sv
// Shared definitions for the NEC IR receiver: FSM state encoding,
// nominal protocol pulse widths and the tolerance window helper.
package ir_nec_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_LEAD_M   = 3'd1;
    localparam state_t ST_LEAD_S   = 3'd2;
    localparam state_t ST_BIT_M    = 3'd3;
    localparam state_t ST_BIT_S    = 3'd4;
    localparam state_t ST_STOP     = 3'd5;
    localparam state_t ST_RPT_STOP = 3'd6;
    localparam state_t ST_CHECK    = 3'd7;

    // Nominal NEC pulse widths in microseconds
    localparam int unsigned NOM_LEAD_M_US = 9000;
    localparam int unsigned NOM_LEAD_S_US = 4500;
    localparam int unsigned NOM_RPT_S_US  = 2250;
    localparam int unsigned NOM_BIT_US    = 560;
    localparam int unsigned NOM_ONE_S_US  = 1690;

    // Window bound around a nominal width; hi=0 gives the lower bound
    function automatic int unsigned win_bound(input int unsigned nom,
                                              input int unsigned tol,
                                              input bit          hi);
        if (hi) begin
            return (nom * (32'd100 + tol)) / 32'd100;
        end else begin
            return (nom * (32'd100 - tol)) / 32'd100;
        end
    endfunction

endpackage

// File: rtl/ir_pulse_timer.sv
// Input conditioning and pulse measurement: synchroniser, glitch filter,
// microsecond prescaler, saturating width counter, edge events and timeout.
module ir_pulse_timer
    import ir_nec_pkg::*;
#(
    parameter int unsigned DIV      = 50,
    parameter int unsigned FILT_CYC = 8,
    parameter int unsigned TIMEOUT  = 12000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        irda_i,
    output logic        ev_o,
    output logic        ev_level_o,
    output logic [13:0] ev_us_o,
    output logic        timeout_o
);

    localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned FW = (FILT_CYC > 1) ? $clog2(FILT_CYC) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
    localparam logic [FW-1:0] FILT_MAX  = FW'(FILT_CYC - 1);
    localparam logic [13:0]   TO_LIM    = 14'(TIMEOUT);

    logic          sync1_q, sync2_q;
    logic          filt_q, filt_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic [PW-1:0] presc_q;
    logic [13:0]   us_q;
    logic          ev_q, ev_level_q;
    logic [13:0]   ev_us_q;
    logic          edge_s, tick_s;

    // Two-flop synchroniser; idle line level is high
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= irda_i;
            sync2_q <= sync1_q;
        end
    end

    // Glitch filter: level follows input only after FILT_CYC disagreeing clocks
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        if (sync2_q == filt_q) begin
            fcnt_d = '0;
        end else if (fcnt_q == FILT_MAX) begin
            filt_d = sync2_q;
            fcnt_d = '0;
        end else begin
            fcnt_d = fcnt_q + FW'(1);
        end
    end

    // Filter state registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            filt_q <= 1'b1;
            fcnt_q <= '0;
        end else begin
            filt_q <= filt_d;
            fcnt_q <= fcnt_d;
        end
    end

    assign edge_s = (filt_d != filt_q);
    assign tick_s = (presc_q == PRESC_MAX);

    // Prescaler and width counter restart on each edge, which also emits the event
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            presc_q    <= '0;
            us_q       <= 14'd0;
            ev_q       <= 1'b0;
            ev_level_q <= 1'b1;
            ev_us_q    <= 14'd0;
        end else if (edge_s) begin
            presc_q    <= '0;
            us_q       <= 14'd0;
            ev_q       <= 1'b1;
            ev_level_q <= filt_q;
            ev_us_q    <= us_q;
        end else begin
            ev_q <= 1'b0;
            if (tick_s) begin
                presc_q <= '0;
                if (us_q != 14'h3FFF) begin
                    us_q <= us_q + 14'd1;
                end
            end else begin
                presc_q <= presc_q + PW'(1);
            end
        end
    end

    assign ev_o       = ev_q;
    assign ev_level_o = ev_level_q;
    assign ev_us_o    = ev_us_q;
    assign timeout_o  = (us_q > TO_LIM);

endmodule

// File: rtl/ir_nec_rx.sv
// NEC IR frame decoder with repeat-code support, integrity checks,
// error pulse, sticky overflow and a valid/ready output handshake.
// TIME_DIV divides every nominal width and the timeout; 1 for real remotes.
module ir_nec_rx
    import ir_nec_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50000000,
    parameter int unsigned TOL_PCT    = 20,
    parameter int unsigned FILT_CYC   = 8,
    parameter int unsigned EXT_ADDR   = 0,
    parameter int unsigned REPEAT_EN  = 1,
    parameter int unsigned TIMEOUT_US = 12000,
    parameter int unsigned TIME_DIV   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        irda,
    output logic [7:0]  cmd,
    output logic [15:0] addr,
    output logic        rpt,
    output logic        valid,
    input  logic        ready,
    output logic        err,
    output logic        ovf
);

    localparam int unsigned DIV = CLK_HZ / 1000000;
    localparam logic [13:0] LM_LO = 14'(win_bound(NOM_LEAD_M_US / TIME_DIV, TOL_PCT, 1'b0));
    localparam logic [13:0] LM_HI = 14'(win_bound(NOM_LEAD_M_US / TIME_DIV, TOL_PCT, 1'b1));
    localparam logic [13:0] LS_LO = 14'(win_bound(NOM_LEAD_S_US / TIME_DIV, TOL_PCT, 1'b0));
    localparam logic [13:0] LS_HI = 14'(win_bound(NOM_LEAD_S_US / TIME_DIV, TOL_PCT, 1'b1));
    localparam logic [13:0] RS_LO = 14'(win_bound(NOM_RPT_S_US / TIME_DIV, TOL_PCT, 1'b0));
    localparam logic [13:0] RS_HI = 14'(win_bound(NOM_RPT_S_US / TIME_DIV, TOL_PCT, 1'b1));
    localparam logic [13:0] B_LO  = 14'(win_bound(NOM_BIT_US / TIME_DIV, TOL_PCT, 1'b0));
    localparam logic [13:0] B_HI  = 14'(win_bound(NOM_BIT_US / TIME_DIV, TOL_PCT, 1'b1));
    localparam logic [13:0] O_LO  = 14'(win_bound(NOM_ONE_S_US / TIME_DIV, TOL_PCT, 1'b0));
    localparam logic [13:0] O_HI  = 14'(win_bound(NOM_ONE_S_US / TIME_DIV, TOL_PCT, 1'b1));

    function automatic logic in_win(input logic [13:0] d, input logic [13:0] lo,
                                    input logic [13:0] hi);
        return (d >= lo) && (d <= hi);
    endfunction

    logic        ev_s, ev_level_s, timeout_s;
    logic [13:0] ev_us_s;

    ir_pulse_timer #(
        .DIV      (DIV),
        .FILT_CYC (FILT_CYC),
        .TIMEOUT  (TIMEOUT_US / TIME_DIV)
    ) u_timer (
        .clk_i      (clk),
        .rst_ni     (rst),
        .irda_i     (irda),
        .ev_o       (ev_s),
        .ev_level_o (ev_level_s),
        .ev_us_o    (ev_us_s),
        .timeout_o  (timeout_s)
    );

    state_t      state_q, state_d;
    logic [4:0]  bitcnt_q, bitcnt_d;
    logic [31:0] shreg_q, shreg_d;
    logic [7:0]  last_cmd_q, cmd_q;
    logic [15:0] last_addr_q, addr_q;
    logic        have_last_q, rpt_q, valid_q, err_q, ovf_q;
    logic        err_s, emit_s, emit_rpt_s, last_load_s, accept_s, chk_ok_s;
    logic [7:0]  emit_cmd_s;
    logic [15:0] emit_addr_s;

    assign chk_ok_s = (shreg_q[31:24] == ~shreg_q[23:16]) &&
                      ((EXT_ADDR != 0) || (shreg_q[15:8] == ~shreg_q[7:0]));

    // Frame FSM: window checks on each timer event, timeout abort, final check
    always_comb begin
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        shreg_d     = shreg_q;
        err_s       = 1'b0;
        emit_s      = 1'b0;
        emit_rpt_s  = 1'b0;
        emit_cmd_s  = 8'h00;
        emit_addr_s = 16'h0000;
        last_load_s = 1'b0;
        if ((state_q != ST_IDLE) && (state_q != ST_CHECK) && timeout_s) begin
            err_s   = 1'b1;
            state_d = ST_IDLE;
        end else if (state_q == ST_CHECK) begin
            state_d = ST_IDLE;
            if (chk_ok_s) begin
                emit_s      = 1'b1;
                emit_cmd_s  = shreg_q[23:16];
                emit_addr_s = (EXT_ADDR != 0) ? shreg_q[15:0] : {8'h00, shreg_q[7:0]};
                last_load_s = 1'b1;
            end else begin
                err_s = 1'b1;
            end
        end else if (ev_s) begin
            case (state_q)
                ST_IDLE: begin
                    if (ev_level_s) begin
                        state_d = ST_LEAD_M;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_LEAD_M: begin
                    if (in_win(ev_us_s, LM_LO, LM_HI)) begin
                        state_d = ST_LEAD_S;
                    end else begin
                        err_s   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                ST_LEAD_S: begin
                    if (in_win(ev_us_s, LS_LO, LS_HI)) begin
                        state_d  = ST_BIT_M;
                        bitcnt_d = 5'd0;
                    end else if ((REPEAT_EN != 0) && in_win(ev_us_s, RS_LO, RS_HI)) begin
                        state_d = ST_RPT_STOP;
                    end else begin
                        err_s   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                ST_BIT_M: begin
                    if (in_win(ev_us_s, B_LO, B_HI)) begin
                        state_d = ST_BIT_S;
                    end else begin
                        err_s   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                ST_BIT_S: begin
                    if (in_win(ev_us_s, B_LO, B_HI) || in_win(ev_us_s, O_LO, O_HI)) begin
                        shreg_d  = {in_win(ev_us_s, O_LO, O_HI), shreg_q[31:1]};
                        bitcnt_d = bitcnt_q + 5'd1;
                        state_d  = (bitcnt_q == 5'd31) ? ST_STOP : ST_BIT_M;
                    end else begin
                        err_s   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                ST_STOP: begin
                    if (in_win(ev_us_s, B_LO, B_HI)) begin
                        state_d = ST_CHECK;
                    end else begin
                        err_s   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                ST_RPT_STOP: begin
                    state_d = ST_IDLE;
                    if (in_win(ev_us_s, B_LO, B_HI) && have_last_q) begin
                        emit_s      = 1'b1;
                        emit_rpt_s  = 1'b1;
                        emit_cmd_s  = last_cmd_q;
                        emit_addr_s = last_addr_q;
                    end else begin
                        err_s = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // FSM, shift register, last-good-frame memory and error pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            bitcnt_q    <= 5'd0;
            shreg_q     <= 32'h0000_0000;
            last_cmd_q  <= 8'h00;
            last_addr_q <= 16'h0000;
            have_last_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            shreg_q  <= shreg_d;
            err_q    <= err_s;
            if (last_load_s) begin
                last_cmd_q  <= emit_cmd_s;
                last_addr_q <= emit_addr_s;
                have_last_q <= 1'b1;
            end
        end
    end

    assign accept_s = valid_q & ready;

    // Output handshake: a word held with ready low is never overwritten
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd_q   <= 8'h00;
            addr_q  <= 16'h0000;
            rpt_q   <= 1'b0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            if (emit_s && (!valid_q || accept_s)) begin
                cmd_q   <= emit_cmd_s;
                addr_q  <= emit_addr_s;
                rpt_q   <= emit_rpt_s;
                valid_q <= 1'b1;
            end else if (accept_s) begin
                valid_q <= 1'b0;
            end
            if (accept_s) begin
                ovf_q <= 1'b0;
            end else if (emit_s && valid_q) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign cmd   = cmd_q;
    assign addr  = addr_q;
    assign rpt   = rpt_q;
    assign valid = valid_q;
    assign err   = err_q;
    assign ovf   = ovf_q;

endmodule
